// File: rtl/clock_divider_pkg.sv
// Shared defaults and sizing helpers for the multi-channel clock divider.
package clock_divider_pkg;

  localparam int CNT_W_DEF       = 17;
  localparam int DIV_DEFAULT_DEF = 100000;

  // Width of a channel index; a single-channel build still needs one select bit.
  function automatic int ch_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/clock_divider_channel.sv
// One divider channel: counter, active/shadow divide pair and glitch-free
// divide switching at half-period boundaries.
module clock_divider_channel
  import clock_divider_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DIV_DEFAULT = DIV_DEFAULT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_div,
  output logic             pending,
  output logic             clk_out,
  output logic             tick
);

  localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_DEFAULT);

  logic [CNT_W-1:0] div_q;
  logic [CNT_W-1:0] shadow_q;
  logic [CNT_W-1:0] cnt_q;
  logic             pending_q;
  logic             clk_out_q;
  logic             tick_q;

  logic terminal;
  logic apply;

  assign terminal = (cnt_q == div_q);
  // A stopped channel has no half-period in flight, so it may switch at once.
  assign apply    = pending_q && (sync || !en || terminal);

  // NOTE: every state register uses <= so all of them sample the same pre-edge
  // values; a blocking write here would let later statements see the new value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q     <= DIV_INIT;
      shadow_q  <= DIV_INIT;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      if (sync) begin
        cnt_q     <= '0;
        clk_out_q <= 1'b0;
      end else if (en) begin
        if (terminal) begin
          cnt_q     <= '0;
          clk_out_q <= ~clk_out_q;
          tick_q    <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
      if (apply) begin
        div_q     <= shadow_q;
        pending_q <= 1'b0;
      end
      // Writes are only accepted while nothing is pending, so this never
      // collides with an apply in the same cycle.
      if (wr) begin
        shadow_q  <= wr_div;
        pending_q <= 1'b1;
      end
    end
  end

  assign pending = pending_q;
  assign clk_out = clk_out_q;
  assign tick    = tick_q;

endmodule

// File: rtl/clock_divider_multi.sv
// Multi-channel programmable clock divider: shared configuration port with a
// per-channel shadow register, global phase-alignment restart.
module clock_divider_multi
  import clock_divider_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DIV_DEFAULT = DIV_DEFAULT_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_CH-1:0]         en,
  input  logic                      sync,
  input  logic                      cfg_valid,
  input  logic [ch_w(NUM_CH)-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]          cfg_div,
  output logic                      cfg_ready,
  output logic [NUM_CH-1:0]         clk_out,
  output logic [NUM_CH-1:0]         tick
);

  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] wr;

  // NOTE: cfg_ready gets its default before the loop so every path assigns it
  // and no latch is inferred; out-of-range channels keep the default of 1.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (32'(cfg_ch) == 32'(i)) cfg_ready = ~pending[i];
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign wr[g] = cfg_valid && cfg_ready && (32'(cfg_ch) == 32'(g));

    clock_divider_channel #(
      .CNT_W       (CNT_W),
      .DIV_DEFAULT (DIV_DEFAULT)
    ) u_channel (
      .clk     (clk),
      .reset   (reset),
      .en      (en[g]),
      .sync    (sync),
      .wr      (wr[g]),
      .wr_div  (cfg_div),
      .pending (pending[g]),
      .clk_out (clk_out[g]),
      .tick    (tick[g])
    );
  end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Self-checking bench: directed scenarios plus random traffic, compared every
// cycle against a behavioural per-channel model.
module tb_clock_divider_multi;

  localparam int NUM_CH      = 2;
  localparam int CNT_W       = 4;
  localparam int DIV_DEFAULT = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       en;
  logic             sync;
  logic             cfg_valid;
  logic [0:0]       cfg_ch;
  logic [3:0]       cfg_div;
  logic             cfg_ready;
  logic [1:0]       clk_out;
  logic [1:0]       tick;

  clock_divider_multi #(
    .NUM_CH      (NUM_CH),
    .CNT_W       (CNT_W),
    .DIV_DEFAULT (DIV_DEFAULT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .sync      (sync),
    .cfg_valid (cfg_valid),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .clk_out   (clk_out),
    .tick      (tick)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: per-channel divide, shadow, pending flag, count, outputs.
  int m_d[NUM_CH];
  int m_sh[NUM_CH];
  int m_pend[NUM_CH];
  int m_c[NUM_CH];
  int m_co[NUM_CH];
  int m_tk[NUM_CH];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_d[i] = DIV_DEFAULT; m_sh[i] = DIV_DEFAULT; m_pend[i] = 0;
      m_c[i] = 0; m_co[i] = 0; m_tk[i] = 0;
    end
  endtask

  function automatic logic [1:0] exp_clk();
    return {m_co[1][0], m_co[0][0]};
  endfunction

  function automatic logic [1:0] exp_tick();
    return {m_tk[1][0], m_tk[0][0]};
  endfunction

  // One rising edge of the model, given the inputs that were stable before it.
  task automatic model_step(input logic [1:0] e, input logic s, input logic v,
                            input logic [0:0] ch, input logic [3:0] dv);
    for (int i = 0; i < NUM_CH; i++) begin
      bit hs = v && (int'(ch) == i) && (m_pend[i] == 0);
      bit running = e[i];
      m_tk[i] = 0;
      if (s) begin
        m_c[i] = 0; m_co[i] = 0;
        if (m_pend[i] != 0) begin m_d[i] = m_sh[i]; m_pend[i] = 0; end
      end else if (running) begin
        if (m_c[i] == m_d[i]) begin
          m_c[i] = 0; m_co[i] = 1 - m_co[i]; m_tk[i] = 1;
          if (m_pend[i] != 0) begin m_d[i] = m_sh[i]; m_pend[i] = 0; end
        end else begin
          m_c[i] = (m_c[i] + 1) % 16;
        end
      end else if (m_pend[i] != 0) begin
        m_d[i] = m_sh[i]; m_pend[i] = 0;
      end
      if (hs) begin m_sh[i] = int'(dv); m_pend[i] = 1; end
    end
  endtask

  task automatic compare_outputs();
    check("clk_out", 32'(clk_out), 32'(exp_clk()));
    check("tick", 32'(tick), 32'(exp_tick()));
  endtask

  // Called just after a falling edge; leaves the bench just after the next one.
  task automatic cycle(input logic [1:0] e, input logic s, input logic v,
                       input logic [0:0] ch, input logic [3:0] dv);
    en = e; sync = s; cfg_valid = v; cfg_ch = ch; cfg_div = dv;
    #1;
    check("cfg_ready", 32'(cfg_ready), 32'(m_pend[ch] == 0));
    @(posedge clk);
    model_step(e, s, v, ch, dv);
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(2'b11, 1'b0, 1'b0, 1'b0, 4'd0);
  endtask

  // Bounded wait until channel ch has nothing pending.
  task automatic wait_ready(input logic [0:0] ch);
    int budget = 64;
    while (m_pend[ch] != 0 && budget > 0) begin
      cycle(2'b11, 1'b0, 1'b0, ch, 4'd0);
      budget--;
    end
    if (budget == 0) check("wait_ready_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] held;
    int budget;

    reset = 1'b0; en = '0; sync = 1'b0; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0;
    model_reset();
    @(negedge clk); @(negedge clk);
    check("reset_clk_out", 32'(clk_out), 32'd0);
    check("reset_tick", 32'(tick), 32'd0);
    check("reset_cfg_ready", 32'(cfg_ready), 32'd1);
    reset = 1'b1;

    // D=3: first toggle on the fourth edge, then every four edges.
    idle(3);
    check("first_half_low", 32'(clk_out), 32'd0);
    idle(1);
    check("first_toggle_clk", 32'(clk_out), 32'h3);
    check("first_toggle_tick", 32'(tick), 32'h3);
    idle(1);
    check("tick_one_cycle", 32'(tick), 32'd0);
    idle(3);
    check("second_toggle_clk", 32'(clk_out), 32'd0);
    idle(8);

    // Mid-half-period update of ch0 to D=1.
    idle(1);
    cycle(2'b11, 1'b0, 1'b1, 1'b0, 4'd1);
    check("ch0_ready_low", 32'(cfg_ready), 32'd0);
    idle(16);

    // ch1 to D=0: toggles every cycle once applied.
    wait_ready(1'b1);
    cycle(2'b11, 1'b0, 1'b1, 1'b1, 4'd0);
    idle(8);
    for (int k = 0; k < 3; k++) begin
      idle(1);
      check("ch1_tick_constant", 32'(tick[1]), 32'd1);
    end

    // ch0 paused for five cycles holds its output.
    idle(1);
    held = clk_out;
    for (int k = 0; k < 5; k++) begin
      cycle(2'b10, 1'b0, 1'b0, 1'b0, 4'd0);
      check("ch0_hold", 32'(clk_out[0]), 32'(held[0]));
    end
    idle(10);

    // Sync coincident with ch0 terminal count while an update is pending.
    wait_ready(1'b0);
    budget = 64;
    while (m_c[0] == m_d[0] && budget > 0) begin idle(1); budget--; end
    cycle(2'b11, 1'b0, 1'b1, 1'b0, 4'd2);
    while (!(m_c[0] == m_d[0] && m_pend[0] != 0) && budget > 0) begin idle(1); budget--; end
    if (budget == 0) check("sync_setup_timeout", 32'd0, 32'd1);
    cycle(2'b11, 1'b1, 1'b0, 1'b0, 4'd0);
    check("sync_clk_out", 32'(clk_out), 32'd0);
    check("sync_tick", 32'(tick), 32'd0);
    idle(2);
    check("sync_new_div_low", 32'(clk_out[0]), 32'd0);
    idle(1);
    check("sync_new_div_toggle", 32'(clk_out[0]), 32'd1);

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      logic [1:0] e;
      e[0] = ($urandom_range(0, 4) != 0);
      e[1] = ($urandom_range(0, 4) != 0);
      cycle(e, ($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    end

    // Asynchronous reset mid-period with an update pending.
    wait_ready(1'b0);
    cycle(2'b11, 1'b0, 1'b1, 1'b0, 4'd5);
    idle(1);
    cfg_ch = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("async_reset_clk_out", 32'(clk_out), 32'd0);
    check("async_reset_tick", 32'(tick), 32'd0);
    check("async_reset_ready", 32'(cfg_ready), 32'd1);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    idle(3);
    check("post_reset_low", 32'(clk_out), 32'd0);
    idle(1);
    check("post_reset_default_div", 32'(clk_out), 32'h3);
    idle(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
